// File: rtl/tqvp_vga_capture_pkg.sv
// rtl/tqvp_vga_capture_pkg.sv - register map, capture FSM encoding and STATUS layout
package tqvp_vga_capture_pkg;

    localparam logic [5:0] ADDR_CTRL        = 6'h00;
    localparam logic [5:0] ADDR_LINE_SEL    = 6'h04;
    localparam logic [5:0] ADDR_X_START     = 6'h08;
    localparam logic [5:0] ADDR_X_STEP      = 6'h0C;
    localparam logic [5:0] ADDR_COLOR_MASK  = 6'h10;
    localparam logic [5:0] ADDR_LINE_LEN    = 6'h14;
    localparam logic [5:0] ADDR_FRAME_LINES = 6'h18;
    localparam logic [5:0] ADDR_CUR_Y       = 6'h1C;
    localparam logic [5:0] ADDR_BUF_BASE    = 6'h20;
    localparam logic [5:0] ADDR_CHECKSUM    = 6'h38;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_WAIT_LINE = 3'd2,
        ST_WAIT_X    = 3'd3,
        ST_SAMPLE    = 3'd4,
        ST_DONE      = 3'd5
    } cap_state_t;

    localparam int STATUS_DONE_BIT  = 0;
    localparam int STATUS_STATE_LSB = 1;
    localparam int STATUS_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(logic [7:0] count, cap_state_t st, logic done);
        logic [31:0] s;
        s = '0;
        s[STATUS_COUNT_LSB +: 8] = count;
        s[STATUS_STATE_LSB +: 3] = st;
        s[STATUS_DONE_BIT]       = done;
        return s;
    endfunction

endpackage

// File: rtl/tqvp_vga_capture_if.sv
// rtl/tqvp_vga_capture_if.sv - TinyQV peripheral register bus
interface tqvp_vga_capture_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_vga_capture_vga_sync_meter.sv
// rtl/tqvp_vga_capture_vga_sync_meter.sv - sync edge detect, x/y counters, line/frame measurement
module vga_sync_meter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             hsync_pol,
    input  logic             vsync_pol,
    output logic             hs_act,
    output logic             vs_act,
    output logic             lead_h,
    output logic             lead_v,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] line_len,
    output logic [9:0]       y,
    output logic [9:0]       y_next,
    output logic [9:0]       frame_lines
);

    logic hs_q;
    logic vs_q;

    assign hs_act = hsync ~^ hsync_pol;
    assign vs_act = vsync ~^ vsync_pol;
    assign lead_h = hs_act & ~hs_q;
    assign lead_v = vs_act & ~vs_q;

    // vsync has priority so a coincident hsync edge starts line 0, not line 1
    assign y_next = lead_v ? 10'd0 :
                    (lead_h && y != 10'h3FF) ? y + 10'd1 : y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            x           <= '0;
            line_len    <= '0;
            y           <= '0;
            frame_lines <= '0;
        end else begin
            hs_q <= hs_act;
            vs_q <= vs_act;
            if (lead_h) begin
                x        <= '0;
                line_len <= x + CNT_W'(1);
            end else if (x != {CNT_W{1'b1}}) begin
                x <= x + CNT_W'(1);
            end
            y <= y_next;
            if (lead_v) begin
                frame_lines <= y;
            end
        end
    end

endmodule

// File: rtl/tqvp_vga_capture.sv
// rtl/tqvp_vga_capture.sv - VGA stream measurement and scanline capture; VGA_CAPTURE_CHECKSUM_EN adds a frame checksum at 0x38
module tqvp_vga_capture
    import tqvp_vga_capture_pkg::*;
#(
    parameter int SAMPLES = 192,
    parameter int CNT_W   = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           ui_in,
    output logic [7:0]           uo_out,
    tqvp_vga_capture_if.slave    bus,
    output logic                 user_interrupt
);

    localparam int IDX_W = $clog2(SAMPLES + 1);

    logic             hsync_pol, vsync_pol;
    logic [9:0]       line_sel;
    logic [CNT_W-1:0] x_start;
    logic [6:0]       x_step;
    logic [5:0]       color_mask;
    logic             done;
    logic [IDX_W-1:0] idx;
    logic [6:0]       step_cnt;
    logic [SAMPLES-1:0] cap_buf;
    cap_state_t       state, state_d;

    logic             hs_act, vs_act, lead_h, lead_v;
    logic [CNT_W-1:0] x, line_len;
    logic [9:0]       y, y_next, frame_lines;
    logic [15:0]      checksum;

    logic             wr_en, ctrl_wr, status_rd;
    logic [5:0]       bbggrr;
    logic             sample_bit;
    logic             take_sample, set_done;
    logic [31:0]      rdata;

    vga_sync_meter #(.CNT_W(CNT_W)) u_meter (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsync       (ui_in[7]),
        .vsync       (ui_in[3]),
        .hsync_pol   (hsync_pol),
        .vsync_pol   (vsync_pol),
        .hs_act      (hs_act),
        .vs_act      (vs_act),
        .lead_h      (lead_h),
        .lead_v      (lead_v),
        .x           (x),
        .line_len    (line_len),
        .y           (y),
        .y_next      (y_next),
        .frame_lines (frame_lines)
    );

    assign wr_en      = bus.data_write_n != 2'b11;
    assign ctrl_wr    = wr_en && bus.address == ADDR_CTRL;
    assign status_rd  = bus.data_read_n != 2'b11 && bus.address == ADDR_CTRL;
    assign bbggrr     = {ui_in[6:4], ui_in[2:0]};
    assign sample_bit = |(bbggrr & color_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_ARMED: begin
                if (lead_v) begin
                    state_d = (lead_h && y_next == line_sel) ? ST_WAIT_X : ST_WAIT_LINE;
                end
            end
            ST_WAIT_LINE: begin
                if (lead_h && y_next == line_sel) begin
                    state_d = ST_WAIT_X;
                end
            end
            ST_WAIT_X: begin
                if (x == x_start) begin
                    state_d = ST_SAMPLE;
                end else if (lead_h) begin
                    state_d = ST_DONE;
                end
            end
            ST_SAMPLE: begin
                if (lead_h) begin
                    state_d = ST_DONE;
                end else if (step_cnt == 7'd0 && idx == IDX_W'(SAMPLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_IDLE, ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
        if (ctrl_wr) begin
            state_d = bus.data_in[0] ? ST_ARMED : ST_IDLE;
        end
    end

    always_comb begin
        take_sample = 1'b0;
        case (state)
            ST_WAIT_X: take_sample = (x == x_start);
            ST_SAMPLE: take_sample = !lead_h && step_cnt == 7'd0;
            default:   take_sample = 1'b0;
        endcase
        set_done       = (state_d == ST_DONE) && (state != ST_DONE);
        user_interrupt = done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_pol  <= 1'b0;
            vsync_pol  <= 1'b0;
            line_sel   <= '0;
            x_start    <= '0;
            x_step     <= '0;
            color_mask <= 6'h3F;
            done       <= 1'b0;
            idx        <= '0;
            step_cnt   <= '0;
            cap_buf    <= '0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        hsync_pol <= bus.data_in[1];
                        vsync_pol <= bus.data_in[2];
                    end
                    ADDR_LINE_SEL:   line_sel   <= bus.data_in[9:0];
                    ADDR_X_START:    x_start    <= bus.data_in[CNT_W-1:0];
                    ADDR_X_STEP:     x_step     <= bus.data_in[6:0];
                    ADDR_COLOR_MASK: color_mask <= bus.data_in[5:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                done <= 1'b0;
                if (bus.data_in[0]) begin
                    idx      <= '0;
                    step_cnt <= '0;
                end
            end else begin
                if (take_sample) begin
                    if (idx < IDX_W'(SAMPLES)) begin
                        cap_buf[idx] <= sample_bit;
                        idx          <= idx + IDX_W'(1);
                    end
                    step_cnt <= x_step;
                end else if (state == ST_SAMPLE) begin
                    step_cnt <= step_cnt - 7'd1;
                end
                if (set_done) begin
                    done <= 1'b1;
                end else if (status_rd) begin
                    done <= 1'b0;
                end
            end
        end
    end

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] cks_acc;
    logic [15:0] cks_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_acc   <= '0;
            cks_frame <= '0;
        end else if (lead_v) begin
            cks_frame <= cks_acc;
            cks_acc   <= '0;
        end else if (!hs_act && !vs_act) begin
            cks_acc <= cks_acc + 16'(bbggrr);
        end
    end

    assign checksum = cks_frame;
`else
    assign checksum = 16'd0;
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL:        rdata = pack_status(8'(idx), state, done);
            ADDR_LINE_SEL:    rdata = 32'(line_sel);
            ADDR_X_START:     rdata = 32'(x_start);
            ADDR_X_STEP:      rdata = 32'(x_step);
            ADDR_COLOR_MASK:  rdata = 32'(color_mask);
            ADDR_LINE_LEN:    rdata = 32'(line_len);
            ADDR_FRAME_LINES: rdata = 32'(frame_lines);
            ADDR_CUR_Y:       rdata = 32'(y);
            ADDR_CHECKSUM:    rdata = 32'(checksum);
            default:          rdata = '0;
        endcase
        for (int w = 0; w < SAMPLES / 32; w++) begin
            if (bus.address == ADDR_BUF_BASE + 6'(4 * w)) begin
                rdata = cap_buf[w*32 +: 32];
            end
        end
    end

    assign bus.data_out   = rdata;
    assign bus.data_ready = 1'b1;
    assign uo_out         = 8'd0;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.data_in[31:11], hs_act, vs_act};

endmodule

// File: tb/tb_tqvp_vga_capture.sv
// tb/tb_tqvp_vga_capture.sv - directed scoreboard bench for tqvp_vga_capture
module tb_tqvp_vga_capture;
    import tqvp_vga_capture_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uo_out;
    logic       user_interrupt;

    tqvp_vga_capture_if bus ();

    tqvp_vga_capture dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .bus            (bus),
        .user_interrupt (user_interrupt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // video source configuration and position (p = clock within line, ln = line within frame)
    int gen_on = 0, gen_len = 100, gen_hs = 10, gen_lines = 20, gen_vs = 2, gen_voff = 50;
    int gen_act_high = 1, gen_mode = 0;
    logic [5:0] gen_pix = 6'h00;
    int gen_p = 0, gen_ln = 0;

    initial begin : video
        int pos, xd;
        logic hs, vs;
        logic [5:0] pix;
        forever begin
            @(posedge clk);
            #1;
            if (gen_on != 0) begin
                if (gen_p >= gen_len - 1) begin
                    gen_p  = 0;
                    gen_ln = (gen_ln >= gen_lines - 1) ? 0 : gen_ln + 1;
                end else begin
                    gen_p++;
                end
                pos = gen_ln * gen_len + gen_p;
                hs  = gen_p < gen_hs;
                vs  = pos >= gen_voff && pos < gen_voff + gen_vs * gen_len;
                xd  = (gen_p == 0) ? gen_len - 1 : gen_p - 1;
                if (gen_mode == 1)
                    pix = (gen_ln != 5) ? 6'h01 : (((xd >> 1) & 1) == 0 ? 6'h01 : 6'h00);
                else
                    pix = gen_pix;
                if (gen_act_high == 0) begin
                    hs = !hs;
                    vs = !vs;
                end
                ui_in = {hs, pix[5:3], vs, pix[2:0]};
            end
        end
    end

    typedef struct {
        string       tag;
        logic [5:0]  addr;
        logic [31:0] mask;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address      = a;
        bus.data_in      = d;
        bus.data_write_n = 2'b10;
        @(posedge clk);
        #2 bus.data_write_n = 2'b11;
    endtask

    task automatic reg_read(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.address     = a;
        bus.data_read_n = 2'b10;
        #1 v = bus.data_out;
        @(posedge clk);
        #2 bus.data_read_n = 2'b11;
    endtask

    task automatic expect_reg(input string tag, input logic [5:0] a, input logic [31:0] m,
                              input logic [31:0] e);
        exp_t t;
        t.tag  = tag;
        t.addr = a;
        t.mask = m;
        t.exp  = e;
        sb.push_back(t);
    endtask

    task automatic drain();
        exp_t t;
        logic [31:0] v;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            reg_read(t.addr, v);
            check(t.tag, v & t.mask, t.exp);
        end
    endtask

    task automatic wait_gen(input string tag, input int ln, input int p);
        int n = 0;
        while (!(gen_ln == ln && gen_p == p) && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(gen_ln == ln && gen_p == p), 32'd1);
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n = 0;
        while (user_interrupt !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(user_interrupt), 32'd1);
    endtask

    initial begin : main
        bus.address      = '0;
        bus.data_in      = '0;
        bus.data_write_n = 2'b11;
        bus.data_read_n  = 2'b11;

        // reset state, read while still in reset
        repeat (3) @(negedge clk);
        check("rst_irq", 32'(user_interrupt), 32'd0);
        check("rst_uo_out", 32'(uo_out), 32'd0);
        check("rst_ready", 32'(bus.data_ready), 32'd1);
        expect_reg("rst_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0);
        expect_reg("rst_mask", ADDR_COLOR_MASK, 32'hFFFF_FFFF, 32'h3F);
        expect_reg("rst_line_len", ADDR_LINE_LEN, 32'hFFFF_FFFF, 32'h0);
        expect_reg("rst_frame_lines", ADDR_FRAME_LINES, 32'hFFFF_FFFF, 32'h0);
        expect_reg("rst_buf0", ADDR_BUF_BASE, 32'hFFFF_FFFF, 32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // measurement: 100-clock lines, 20-line frames, active-high syncs
        gen_on = 1;
        reg_write(ADDR_CTRL, 32'h6);
        repeat (5000) @(negedge clk);
        expect_reg("meas_line_len", ADDR_LINE_LEN, 32'hFFFF_FFFF, 32'd100);
        expect_reg("meas_frame_lines", ADDR_FRAME_LINES, 32'hFFFF_FFFF, 32'd20);
        drain();
        wait_gen("sync_y5", 5, 70);
        expect_reg("y_line5", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd5);
        drain();
        wait_gen("sync_y19", 19, 70);
        expect_reg("y_line19", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd19);
        drain();
        wait_gen("sync_y20", 0, 20);
        expect_reg("y_before_vsync", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd20);
        drain();
        wait_gen("sync_y0", 0, 80);
        expect_reg("y_after_vsync", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd0);
        drain();

        // capture line 5 every other clock from x=20; line end stops it at 40 samples
        gen_mode = 1;
        reg_write(ADDR_LINE_SEL, 32'd5);
        reg_write(ADDR_X_START, 32'd20);
        reg_write(ADDR_X_STEP, 32'd1);
        reg_write(ADDR_CTRL, 32'h7);
        wait_irq("cap1_irq", 6000);
        expect_reg("cap1_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_280B);
        expect_reg("cap1_word0", ADDR_BUF_BASE, 32'hFFFF_FFFF, 32'h5555_5555);
        expect_reg("cap1_word1", ADDR_BUF_BASE + 6'd4, 32'hFFFF_FFFF, 32'h0000_0055);
        drain();
        check("cap1_irq_cleared", 32'(user_interrupt), 32'd0);
        expect_reg("cap1_status_after", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_280A);
        drain();

        // full-depth capture on 300-clock lines
        gen_mode = 0;
        gen_pix  = 6'h30;
        gen_len  = 300;
        reg_write(ADDR_COLOR_MASK, 32'h0F);
        reg_write(ADDR_X_STEP, 32'd0);
        reg_write(ADDR_X_START, 32'd0);
        repeat (7000) @(negedge clk);
        reg_write(ADDR_CTRL, 32'h7);
        wait_irq("full0_irq", 13000);
        expect_reg("full0_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_C00B);
        expect_reg("full_line_len", ADDR_LINE_LEN, 32'hFFFF_FFFF, 32'd300);
        for (int w = 0; w < 6; w++)
            expect_reg($sformatf("full0_word%0d", w), ADDR_BUF_BASE + 6'(4 * w), 32'hFFFF_FFFF, 32'h0);
        drain();
        reg_write(ADDR_COLOR_MASK, 32'h30);
        reg_write(ADDR_CTRL, 32'h7);
        wait_irq("full1_irq", 13000);
        expect_reg("full1_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_C00B);
        for (int w = 0; w < 6; w++)
            expect_reg($sformatf("full1_word%0d", w), ADDR_BUF_BASE + 6'(4 * w), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // abort mid-sample
        gen_len = 100;
        gen_pix = 6'h01;
        reg_write(ADDR_COLOR_MASK, 32'h3F);
        reg_write(ADDR_X_START, 32'd10);
        repeat (4500) @(negedge clk);
        wait_gen("abort_sync0", 0, 40);
        reg_write(ADDR_CTRL, 32'h7);
        wait_gen("abort_sync5", 5, 50);
        expect_reg("abort_in_sample", ADDR_CTRL, 32'h0000_000F, 32'(ST_SAMPLE) << 1);
        drain();
        reg_write(ADDR_CTRL, 32'h6);
        expect_reg("abort_idle", ADDR_CTRL, 32'h0000_000F, 32'h0);
        drain();
        repeat (2500) @(negedge clk);
        check("abort_no_irq", 32'(user_interrupt), 32'd0);

        // re-arm during WAIT_X goes back to ARMED, then completes on the next frame
        reg_write(ADDR_X_START, 32'd40);
        wait_gen("rearm_sync0", 0, 40);
        reg_write(ADDR_CTRL, 32'h7);
        wait_gen("rearm_sync5", 5, 5);
        expect_reg("rearm_wait_x", ADDR_CTRL, 32'h0000_000F, 32'(ST_WAIT_X) << 1);
        drain();
        reg_write(ADDR_CTRL, 32'h7);
        expect_reg("rearm_armed", ADDR_CTRL, 32'h0000_000F, 32'(ST_ARMED) << 1);
        drain();
        wait_irq("rearm_irq", 6000);
        expect_reg("rearm_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_3B0B);
        drain();

        // X_START beyond the line: done with zero samples
        reg_write(ADDR_X_START, 32'd200);
        reg_write(ADDR_CTRL, 32'h7);
        wait_irq("xbeyond_irq", 6000);
        expect_reg("xbeyond_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_000B);
        drain();

        // active-low syncs
        reg_write(ADDR_CTRL, 32'h0);
        gen_act_high = 0;
        gen_pix      = 6'h02;
        repeat (4500) @(negedge clk);
        expect_reg("pol_line_len", ADDR_LINE_LEN, 32'hFFFF_FFFF, 32'd100);
        expect_reg("pol_frame_lines", ADDR_FRAME_LINES, 32'hFFFF_FFFF, 32'd20);
        expect_reg("unmapped_3c", 6'h3C, 32'hFFFF_FFFF, 32'h0);
`ifdef VGA_CAPTURE_CHECKSUM_EN
        expect_reg("checksum", ADDR_CHECKSUM, 32'hFFFF_FFFF, 32'd3240);
`else
        expect_reg("checksum_absent", ADDR_CHECKSUM, 32'hFFFF_FFFF, 32'h0);
`endif
        drain();

        // hsync and vsync leading edges coincide
        gen_voff = 0;
        gen_pix  = 6'h01;
        repeat (4500) @(negedge clk);
        expect_reg("sim_frame_lines", ADDR_FRAME_LINES, 32'hFFFF_FFFF, 32'd19);
        drain();
        wait_gen("sim_sync0", 0, 50);
        expect_reg("sim_y0", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd0);
        drain();
        wait_gen("sim_sync1", 1, 50);
        expect_reg("sim_y1", ADDR_CUR_Y, 32'hFFFF_FFFF, 32'd1);
        drain();
        reg_write(ADDR_LINE_SEL, 32'd0);
        reg_write(ADDR_X_START, 32'd5);
        wait_gen("sim_sync19", 19, 50);
        reg_write(ADDR_CTRL, 32'h1);
        wait_irq("line0_irq", 4500);
        expect_reg("line0_status", ADDR_CTRL, 32'hFFFF_FFFF, 32'h0000_5E0B);
        expect_reg("line0_word0", ADDR_BUF_BASE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
